// File: rtl/cmask_batch_sequencer_if.sv
// Command-in / batch-mask-out bundle between command decode and the batch sequencer.
// No storage; wires only.
// cmd_ready is the only backpressure: a command transfers when cmd_valid and cmd_ready are both high.
interface cmask_batch_sequencer_if #(
    parameter int src_size = 10,
    parameter int HOLD_W   = 8
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [src_size-1:0] cmd_start;
    logic [src_size-1:0] cmd_end;
    logic [HOLD_W-1:0]   cmd_hold;
    logic                abort;
    logic [src_size-1:0] C_start;
    logic [src_size-1:0] C_end;
    logic                mask_valid;
    logic                busy;
    logic                done;
    logic                err;

    // command source side (decode logic / testbench)
    modport master (
        output cmd_valid, cmd_start, cmd_end, cmd_hold, abort,
        input  cmd_ready, C_start, C_end, mask_valid, busy, done, err
    );

    // sequencer side
    modport slave (
        input  cmd_valid, cmd_start, cmd_end, cmd_hold, abort,
        output cmd_ready, C_start, C_end, mask_valid, busy, done, err
    );
endinterface

// File: rtl/cmask_batch_sequencer.sv
// Walks a crossbar range [start,end] in batches of at most MAX_ACTIVE crossbars, each held hold cycles.
// First batch two cycles after command acceptance; batches back-to-back; done one cycle after the last.
// Accepts a new command only in IDLE (cmd_ready); a command presented while busy waits until IDLE.
module cmask_batch_sequencer #(
    parameter int num_crossbar = 1024,
    parameter int src_size     = 10,
    parameter int MAX_ACTIVE   = 64,
    parameter int HOLD_W       = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    cmask_batch_sequencer_if.slave bus
);
    // Batch size clamped to a legal 1..num_crossbar range
    localparam int MAX_EFF = (MAX_ACTIVE < 1) ? 1 :
                             ((MAX_ACTIVE > num_crossbar) ? num_crossbar : MAX_ACTIVE);
    localparam int W1 = src_size + 1;
    localparam logic [src_size:0] STEP = W1'(MAX_EFF - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]          state_q;
    logic [src_size-1:0] start_q;
    logic [src_size-1:0] end_q;
    logic [src_size-1:0] cs_q;
    logic [src_size-1:0] ce_q;
    logic [HOLD_W-1:0]   rld_q;
    logic [HOLD_W-1:0]   cnt_q;

    logic [src_size-1:0] load_ce;
    logic [src_size-1:0] next_cs;
    logic [src_size-1:0] next_ce;
    logic                range_bad;

    // Batch end computed one bit wider so cur+MAX_ACTIVE-1 cannot wrap past the top crossbar
    function automatic logic [src_size-1:0] batch_end(input logic [src_size-1:0] cur,
                                                      input logic [src_size-1:0] last);
        logic [src_size:0] sum;
        sum = {1'b0, cur} + STEP;
        if (sum > {1'b0, last})
            return last;
        else
            return sum[src_size-1:0];
    endfunction

    // next_cs only used when ce_q < end_q, so the increment never wraps
    assign next_cs   = ce_q + src_size'(1);
    assign next_ce   = batch_end(next_cs, end_q);
    assign load_ce   = batch_end(start_q, end_q);
    assign range_bad = (start_q > end_q);

    // Control FSM, batch window registers and hold counter
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            start_q <= '0;
            end_q   <= '0;
            cs_q    <= '0;
            ce_q    <= '0;
            rld_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        start_q <= bus.cmd_start;
                        end_q   <= bus.cmd_end;
                        // store hold_eff-1; a zero hold behaves as one cycle
                        rld_q   <= (bus.cmd_hold == '0) ? '0 : bus.cmd_hold - HOLD_W'(1);
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (bus.abort || range_bad) begin
                        state_q <= S_IDLE;
                    end else begin
                        cs_q    <= start_q;
                        ce_q    <= load_ce;
                        cnt_q   <= rld_q;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.abort) begin
                        state_q <= S_IDLE;
                    end else if (cnt_q == '0) begin
                        if (ce_q == end_q) begin
                            state_q <= S_DONE;
                        end else begin
                            cs_q  <= next_cs;
                            ce_q  <= next_ce;
                            cnt_q <= rld_q;
                        end
                    end else begin
                        cnt_q <= cnt_q - HOLD_W'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready  = (state_q == S_IDLE) && !reset;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.mask_valid = (state_q == S_ISSUE);
    assign bus.C_start    = cs_q;
    assign bus.C_end      = ce_q;
    // abort suppresses completion/error pulses in the cycle it arrives
    assign bus.done       = (state_q == S_DONE) && !bus.abort;
    assign bus.err        = (state_q == S_LOAD) && range_bad && !bus.abort;
endmodule
